mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_stage_if.sv | 22 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: memop field positions, size codes,
// FSM state encoding and the default acknowledge timeout.
package mem_pkg;

    localparam int unsigned MemopStoreBit     = 3;
    localparam int unsigned MemopUnsignedBit  = 2;
    localparam int unsigned DefaultAckTimeout = 255;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } mem_size_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mem_state_e;

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] addr_lo);
        return ((size == SizeHalf) && addr_lo[0]) || ((size == SizeWord) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the memory stage: store byte-enables / replicated write data,
// and load byte/half extraction with zero or sign extension.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  mem_size_e   st_size,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  mem_size_e   ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SizeByte: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SizeHalf: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    assign byte_shift = ld_rdata >> {ld_addr_lo, 3'b000};
    assign half_shift = ld_rdata >> {ld_addr_lo[1], 4'b0000};
    assign byte_sign  = ~ld_unsigned & byte_shift[7];
    assign half_sign  = ~ld_unsigned & half_shift[15];

    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            SizeByte: ld_data = {{24{byte_sign}}, byte_shift[7:0]};
            SizeHalf: ld_data = {{16{half_sign}}, half_shift[15:0]};
            default:  ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one data-memory access at a time, stalls EX while busy,
// writes back loads and flags bus timeouts. Optional macro MISALIGN_TRAP_EN traps misaligned ops.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DefaultAckTimeout
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_valid_e,
    input  logic [31:0]        aguout,
    input  logic [31:0]        store_data_e,
    input  logic [3:0]         memop_e,
    input  logic [4:0]         rd_e,
    output logic               stall_m,
    mem_stage_if.master        mem_bus,
    output logic               wb_valid,
    output logic [31:0]        wb_data,
    output logic [4:0]         wb_rd,
    output logic               bus_err,
    output logic               misalign_err
);

    localparam logic [7:0] AckTimeout = 8'(ACK_TIMEOUT);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_err_q, misalign_err_d;

    logic        store_q, store_d;
    logic        unsigned_q, unsigned_d;
    mem_size_e   size_q, size_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;

    mem_size_e   size_in;
    logic        accept;
    logic        trap;
    logic        issue;
    logic        ack_done;
    logic        timed_out;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign size_in = mem_size_e'(memop_e[1:0]);
    assign accept  = (state_q == StIdle) && mem_valid_e && (size_in != SizeRsvd);

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(size_in, aguout[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign issue     = accept && !trap;
    assign cnt_inc   = cnt_q + 8'd1;
    assign ack_done  = (state_q == StBusy) && mem_bus.mem_ack;
    assign timed_out = (state_q == StBusy) && !mem_bus.mem_ack && (cnt_inc == AckTimeout);

    lsu_align u_align (
        .st_addr_lo  (aguout[1:0]),
        .st_size     (size_in),
        .st_data     (store_data_e),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_addr_lo  (addr_lo_q),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (mem_bus.mem_rdata),
        .ld_data     (ld_data)
    );

    // State register plus every registered output; reset clears all of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            store_q        <= 1'b0;
            unsigned_q     <= 1'b0;
            size_q         <= SizeByte;
            addr_lo_q      <= '0;
            rd_q           <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
            store_q        <= store_d;
            unsigned_q     <= unsigned_d;
            size_q         <= size_d;
            addr_lo_q      <= addr_lo_d;
            rd_q           <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_bus.mem_ack || timed_out) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        bus_err_d      = 1'b0;
        misalign_err_d = 1'b0;
        store_d        = store_q;
        unsigned_d     = unsigned_q;
        size_d         = size_q;
        addr_lo_d      = addr_lo_q;
        rd_d           = rd_q;

        if (issue) begin
            req_d      = 1'b1;
            we_d       = memop_e[MemopStoreBit];
            addr_d     = {aguout[31:2], 2'b00};
            be_d       = st_be;
            wdata_d    = st_wdata;
            store_d    = memop_e[MemopStoreBit];
            unsigned_d = memop_e[MemopUnsignedBit];
            size_d     = size_in;
            addr_lo_d  = aguout[1:0];
            rd_d       = rd_e;
        end

        if (accept && trap) begin
            misalign_err_d = 1'b1;
        end

        if (ack_done) begin
            req_d = 1'b0;
            we_d  = 1'b0;
            if (!store_q) begin
                wb_valid_d = 1'b1;
                wb_data_d  = ld_data;
                wb_rd_d    = rd_q;
            end
        end

        if (timed_out) begin
            req_d     = 1'b0;
            we_d      = 1'b0;
            bus_err_d = 1'b1;
        end
    end

    assign stall_m           = (state_q == StBusy);
    assign mem_bus.mem_req   = req_q;
    assign mem_bus.mem_we    = we_q;
    assign mem_bus.mem_addr  = addr_q;
    assign mem_bus.mem_be    = be_q;
    assign mem_bus.mem_wdata = wdata_q;
    assign wb_valid          = wb_valid_q;
    assign wb_data           = wb_data_q;
    assign wb_rd             = wb_rd_q;
    assign bus_err           = bus_err_q;
    assign misalign_err      = misalign_err_q;

endmodule
